// File: rtl/hs_fifo_stage_pkg.sv
// -----------------------------------------------------------------------------
// hs_fifo_stage_pkg
// Shared definitions for the hs_fifo_stage elastic buffer:
//   - default data width and depth
//   - pointer / occupancy width helpers
// Handshake convention on both sides of the stage: an ack is a one-cycle
// pulse and the data word is valid in the same cycle as that pulse.
// -----------------------------------------------------------------------------
package hs_fifo_stage_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 4;

  // Address width for a power-of-two memory; never below one bit.
  function automatic int unsigned ptr_width(input int unsigned entries);
    ptr_width = (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Occupancy needs one more bit than the address so it can hold "full".
  function automatic int unsigned occ_width(input int unsigned entries);
    occ_width = $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// -----------------------------------------------------------------------------
// hs_fifo_mem
// depth x data_width register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from raddr)
// -----------------------------------------------------------------------------
module hs_fifo_mem
  import hs_fifo_stage_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEF,
  parameter int unsigned depth      = DEPTH_DEF,
  parameter int unsigned addr_width = ptr_width(depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_r [depth];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/hs_fifo_stage.sv
// -----------------------------------------------------------------------------
// hs_fifo_stage
// Elastic buffer between a graph output port and a consumer. The upstream side
// acts as a consumer (drives in_req, takes in_ack pulses with data); the
// downstream side acts as a producer (takes out_req, returns out_ack pulses
// with out_dout). Transfers are counted in both directions.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-low reset
//   in_req     out  registered request to upstream producer
//   in_ack     in   upstream ack pulse, in_din valid with it
//   in_din     in   upstream data
//   out_req    in   downstream request level
//   out_ack    out  registered ack pulse to downstream
//   out_dout   out  data, valid with out_ack and held until next pop
//   occupancy  out  number of stored words
//   count_in   out  words accepted since reset (wraps)
//   count_out  out  words delivered since reset (wraps)
//   overflow   out  sticky: in_ack seen while full
// -----------------------------------------------------------------------------
module hs_fifo_stage
  import hs_fifo_stage_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEF,
  parameter int unsigned depth      = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          in_req,
  input  logic                          in_ack,
  input  logic [data_width-1:0]         in_din,
  input  logic                          out_req,
  output logic                          out_ack,
  output logic [data_width-1:0]         out_dout,
  output logic [occ_width(depth)-1:0]   occupancy,
  output logic [31:0]                   count_in,
  output logic [31:0]                   count_out,
  output logic                          overflow
);

  localparam int unsigned AW = ptr_width(depth);
  localparam int unsigned OW = occ_width(depth);

  localparam logic [OW-1:0] OCC_FULL  = OW'(depth);
  localparam logic [OW-1:0] OCC_ZERO  = OW'(0);
  localparam logic [OW-1:0] OCC_ONE   = OW'(1);
  // Request only while at least two slots remain after this edge: the
  // producer may already have an ack in flight when it sees in_req drop.
  localparam logic [OW-1:0] REQ_LIMIT = OW'(depth - 2);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [OW-1:0]         occ_r;
  logic                  in_req_r;
  logic                  out_ack_r;
  logic [data_width-1:0] out_dout_r;
  logic [31:0]           count_in_r;
  logic [31:0]           count_out_r;
  logic                  overflow_r;

  logic                  full_s;
  logic                  push_s;
  logic                  drop_s;
  logic                  pop_s;
  logic [OW-1:0]         occ_next_s;
  logic [data_width-1:0] rd_data_s;

  hs_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_width (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (in_din),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // Push/pop decisions from pre-edge state; no bypass from in_din to out_dout.
  always_comb begin
    full_s = (occ_r == OCC_FULL);
    push_s = 1'b0;
    drop_s = 1'b0;
    pop_s  = 1'b0;
    if (rst) begin
      push_s = in_ack && !full_s;
      drop_s = in_ack && full_s;
      // The out_ack_r term limits delivery to one word every two cycles.
      pop_s  = out_req && !out_ack_r && (occ_r != OCC_ZERO);
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  // Post-edge occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_next_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OCC_ONE;
      2'b01:   occ_next_s = occ_r - OCC_ONE;
      default: occ_next_s = occ_r;
    endcase
  end

  // Pointer, occupancy, handshake, counter and overflow state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      occ_r       <= '0;
      in_req_r    <= 1'b0;
      out_ack_r   <= 1'b0;
      out_dout_r  <= '0;
      count_in_r  <= 32'd0;
      count_out_r <= 32'd0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
        count_in_r <= count_in_r + 32'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        count_out_r <= count_out_r + 32'd1;
        out_dout_r  <= rd_data_s;
      end
      out_ack_r <= pop_s;
      occ_r     <= occ_next_s;
      in_req_r  <= (occ_next_s <= REQ_LIMIT);
    end
  end

  assign in_req    = in_req_r;
  assign out_ack   = out_ack_r;
  assign out_dout  = out_dout_r;
  assign occupancy = occ_r;
  assign count_in  = count_in_r;
  assign count_out = count_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_hs_fifo_stage.sv
// -----------------------------------------------------------------------------
// tb_hs_fifo_stage
// Self-checking bench for hs_fifo_stage (data_width 32, depth 4). Inputs are
// driven on the falling edge and outputs sampled on the falling edge after
// each rising edge. A queue-based reference model tracks the expected state.
// -----------------------------------------------------------------------------
module tb_hs_fifo_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_req;
  logic          in_ack = 1'b0;
  logic [DW-1:0] in_din = '0;
  logic          out_req = 1'b0;
  logic          out_ack;
  logic [DW-1:0] out_dout;
  logic [2:0]    occupancy;
  logic [31:0]   count_in;
  logic [31:0]   count_out;
  logic          overflow;

  always #1 clk = ~clk;

  hs_fifo_stage #(.data_width(DW), .depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_din    (in_din),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_dout  (out_dout),
    .occupancy (occupancy),
    .count_in  (count_in),
    .count_out (count_out),
    .overflow  (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain FIFO queue plus the observable registers.
  logic [DW-1:0] mq[$];
  logic          m_in_req  = 1'b0;
  logic          m_out_ack = 1'b0;
  logic          m_ovf     = 1'b0;
  logic [DW-1:0] m_dout    = '0;
  logic [31:0]   m_cin     = 32'd0;
  logic [31:0]   m_cout    = 32'd0;

  task automatic model_step();
    bit do_pop;
    bit was_full;
    if (!rst) begin
      mq.delete();
      m_in_req  = 1'b0;
      m_out_ack = 1'b0;
      m_ovf     = 1'b0;
      m_dout    = '0;
      m_cin     = 32'd0;
      m_cout    = 32'd0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = out_req && !m_out_ack && (mq.size() > 0);
      if (do_pop) begin
        m_dout = mq.pop_front();
        m_cout = m_cout + 32'd1;
      end
      if (in_ack && was_full) m_ovf = 1'b1;
      else if (in_ack) begin
        mq.push_back(in_din);
        m_cin = m_cin + 32'd1;
      end
      m_out_ack = do_pop;
      m_in_req  = (mq.size() <= DEPTH - 2);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    chk({tag, ".in_req"},    32'(in_req),    32'(m_in_req));
    chk({tag, ".out_ack"},   32'(out_ack),   32'(m_out_ack));
    chk({tag, ".out_dout"},  out_dout,       m_dout);
    chk({tag, ".count_in"},  count_in,       m_cin);
    chk({tag, ".count_out"}, count_out,      m_cout);
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b0; in_ack = 1'b0; out_req = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] din;
    logic        req;
    logic [2:0]  occ;
    logic        oack;
    logic [31:0] dout;
    logic        ireq;
    logic        ovf;
    logic [31:0] cin;
  } vec_t;

  vec_t tv[20];

  initial begin
    int          next_word;
    int          seen;
    int          cyc;
    logic        last_ack;
    logic [31:0] w;

    // rst ack din req | occ oack dout ireq ovf cin  (hand-derived)
    tv[0]  = '{1'b0, 1'b1, 32'hAA,   1'b0, 3'd0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0};
    tv[1]  = '{1'b1, 1'b1, 32'h11,   1'b0, 3'd1, 1'b0, 32'h00, 1'b1, 1'b0, 32'd1};
    tv[2]  = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd0, 1'b1, 32'h11, 1'b1, 1'b0, 32'd1};
    tv[3]  = '{1'b1, 1'b1, 32'h22,   1'b1, 3'd1, 1'b0, 32'h11, 1'b1, 1'b0, 32'd2};
    tv[4]  = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd0, 1'b1, 32'h22, 1'b1, 1'b0, 32'd2};
    tv[5]  = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd0, 1'b0, 32'h22, 1'b1, 1'b0, 32'd2};
    tv[6]  = '{1'b1, 1'b1, 32'h33,   1'b1, 3'd1, 1'b0, 32'h22, 1'b1, 1'b0, 32'd3};
    tv[7]  = '{1'b1, 1'b1, 32'h44,   1'b0, 3'd2, 1'b0, 32'h22, 1'b1, 1'b0, 32'd4};
    tv[8]  = '{1'b1, 1'b1, 32'h55,   1'b0, 3'd3, 1'b0, 32'h22, 1'b0, 1'b0, 32'd5};
    tv[9]  = '{1'b1, 1'b1, 32'h66,   1'b0, 3'd4, 1'b0, 32'h22, 1'b0, 1'b0, 32'd6};
    tv[10] = '{1'b1, 1'b1, 32'hDEAD, 1'b0, 3'd4, 1'b0, 32'h22, 1'b0, 1'b1, 32'd6};
    tv[11] = '{1'b1, 1'b1, 32'h77,   1'b1, 3'd3, 1'b1, 32'h33, 1'b0, 1'b1, 32'd6};
    tv[12] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd3, 1'b0, 32'h33, 1'b0, 1'b1, 32'd6};
    tv[13] = '{1'b1, 1'b1, 32'h88,   1'b1, 3'd3, 1'b1, 32'h44, 1'b0, 1'b1, 32'd7};
    tv[14] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd3, 1'b0, 32'h44, 1'b0, 1'b1, 32'd7};
    tv[15] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd2, 1'b1, 32'h55, 1'b1, 1'b1, 32'd7};
    tv[16] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd2, 1'b0, 32'h55, 1'b1, 1'b1, 32'd7};
    tv[17] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd1, 1'b1, 32'h66, 1'b1, 1'b1, 32'd7};
    tv[18] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd1, 1'b0, 32'h66, 1'b1, 1'b1, 32'd7};
    tv[19] = '{1'b1, 1'b0, 32'h0,    1'b1, 3'd0, 1'b1, 32'h88, 1'b1, 1'b1, 32'd7};

    @(negedge clk);

    // Reset held two cycles with in_ack forced high: everything stays zero.
    rst = 1'b0; in_ack = 1'b1; in_din = 32'h1234; out_req = 1'b1;
    tick();
    tick();
    chk("rst.in_req",    32'(in_req),    32'd0);
    chk("rst.out_ack",   32'(out_ack),   32'd0);
    chk("rst.out_dout",  out_dout,       32'd0);
    chk("rst.occupancy", 32'(occupancy), 32'd0);
    chk("rst.count_in",  count_in,       32'd0);
    chk("rst.count_out", count_out,      32'd0);
    chk("rst.overflow",  32'(overflow),  32'd0);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      rst = tv[i].rst; in_ack = tv[i].ack; in_din = tv[i].din; out_req = tv[i].req;
      tick();
      chk($sformatf("tv%0d.occupancy", i), 32'(occupancy), 32'(tv[i].occ));
      chk($sformatf("tv%0d.out_ack", i),   32'(out_ack),   32'(tv[i].oack));
      chk($sformatf("tv%0d.out_dout", i),  out_dout,       tv[i].dout);
      chk($sformatf("tv%0d.in_req", i),    32'(in_req),    32'(tv[i].ireq));
      chk($sformatf("tv%0d.overflow", i),  32'(overflow),  32'(tv[i].ovf));
      chk($sformatf("tv%0d.count_in", i),  count_in,       tv[i].cin);
      check_model($sformatf("tv%0d.model", i));
    end
    in_ack = 1'b0; out_req = 1'b0;

    // Reset with three words stored; first word out afterwards is post-reset.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_ack = 1'b1; in_din = 32'h100 + 32'(i);
      tick();
    end
    in_ack = 1'b0;
    chk("midrst.occ_before", 32'(occupancy), 32'd3);
    rst = 1'b0;
    tick();
    chk("midrst.occupancy", 32'(occupancy), 32'd0);
    chk("midrst.out_ack",   32'(out_ack),   32'd0);
    rst = 1'b1; in_ack = 1'b1; in_din = 32'h500;
    tick();
    in_ack = 1'b0; out_req = 1'b1;
    cyc = 0;
    while (!out_ack && cyc < 10) begin tick(); cyc++; end
    chk("midrst.got_ack", 32'(out_ack), 32'd1);
    chk("midrst.first",   out_dout,     32'h500);
    check_model("midrst");
    out_req = 1'b0;

    // Simultaneous push and pop with two words stored.
    do_reset();
    in_ack = 1'b1; in_din = 32'hA1; tick();
    in_ack = 1'b0; tick();
    in_ack = 1'b1; in_din = 32'hA2; tick();
    in_ack = 1'b1; in_din = 32'hA3; out_req = 1'b1; tick();
    in_ack = 1'b0;
    chk("simul.occupancy", 32'(occupancy), 32'd2);
    chk("simul.out_ack",   32'(out_ack),   32'd1);
    chk("simul.out_dout",  out_dout,       32'hA1);
    tick(); tick();
    chk("simul.pop2", out_dout, 32'hA2);
    tick(); tick();
    chk("simul.pop3_ack", 32'(out_ack), 32'd1);
    chk("simul.pop3",     out_dout,     32'hA3);
    check_model("simul");
    out_req = 1'b0;

    // Back-pressure: compliant producer, consumer stalled.
    do_reset();
    next_word = 0; last_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_ack = in_req && !last_ack; in_din = 32'(next_word);
      tick();
      if (in_ack) next_word++;
      last_ack = in_ack;
    end
    in_ack = 1'b0;
    chk("bp.occ_ge3",   32'(occupancy >= 3'd3), 32'd1);
    chk("bp.in_req",    32'(in_req),    32'd0);
    chk("bp.overflow",  32'(overflow),  32'd0);
    check_model("bp");
    out_req = 1'b1; seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_ack) begin chk("bp.order", out_dout, 32'(seen)); seen++; end
    end
    chk("bp.drained", 32'(seen), 32'(next_word));
    out_req = 1'b0;

    // Streaming 5000 words, both sides never stalling voluntarily.
    do_reset();
    next_word = 0; seen = 0; last_ack = 1'b0; cyc = 0; out_req = 1'b1;
    while (seen < 5000 && cyc < 30000) begin
      in_ack = in_req && !last_ack && (next_word < 5000); in_din = 32'(next_word);
      tick();
      if (in_ack) next_word++;
      last_ack = in_ack;
      if (out_ack) begin
        if (out_dout !== 32'(seen)) chk("stream.order", out_dout, 32'(seen));
        seen++;
      end
      check_model("stream");
      cyc++;
    end
    in_ack = 1'b0;
    chk("stream.seen",      32'(seen), 32'd5000);
    chk("stream.count_in",  count_in,  32'd5000);
    chk("stream.count_out", count_out, 32'd5000);
    chk("stream.overflow",  32'(overflow), 32'd0);

    // Randomized traffic, including overflow attempts and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) != 0);
      in_ack  = ($urandom_range(0, 1) == 1);
      out_req = ($urandom_range(0, 3) != 0);
      w       = $urandom;
      in_din  = w;
      tick();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
